// File: rtl/ctr_8_pkg.sv
// Shared constants and types for the ctr_8 accumulator.
package ctr_8_pkg;

    // Default datapath width of the accumulator.
    localparam int CTR_8_WIDTH = 8;

    // Count value at the default width.
    typedef logic [CTR_8_WIDTH-1:0] count_t;

endpackage : ctr_8_pkg

// File: rtl/ctr_8_add.sv
// Modulo 2^WIDTH adder. The carry out of the top bit is dropped, so the sum wraps.
module ctr_8_add
    import ctr_8_pkg::*;
#(
    parameter int WIDTH = CTR_8_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    // Sum truncated to WIDTH bits. This is the wrap-around behaviour of the counter.
    always_comb begin
        sum = a + b;
    end

endmodule : ctr_8_add

// File: rtl/ctr_8.sv
// Free-running accumulator: y holds the registered running sum of x modulo 2^WIDTH.
module ctr_8
    import ctr_8_pkg::*;
#(
    parameter int WIDTH = CTR_8_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] add_sum;

    ctr_8_add #(
        .WIDTH (WIDTH)
    ) u_add (
        .a   (count_q),
        .b   (x),
        .sum (add_sum)
    );

    // Next count is always the wrapped sum. Reset priority is applied in the register.
    always_comb begin
        count_d = add_sum;
    end

    // Count register: synchronous reset wins over accumulation on every edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign y = count_q;

endmodule : ctr_8

// File: tb/tb_ctr_8.sv
// Self-checking bench for ctr_8: directed vector table, wrap sweep, and randomized run against a model.
module tb_ctr_8;
    import ctr_8_pkg::*;

    typedef struct {
        logic   rst;
        count_t x;
        count_t exp;
        string  name;
    } vec_t;

    logic   clk;
    logic   reset;
    count_t x;
    count_t y;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    ctr_8 dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs on the falling edge, then step past the next rising edge.
    task automatic applyStimulus(input logic r, input count_t xv);
        @(negedge clk);
        reset = r;
        x     = xv;
        @(posedge clk);
        #1;
    endtask

    // Compare y with the expected value and record the result.
    task automatic checkOutput(input string name, input count_t exp);
        checks++;
        if (y !== exp) begin
            errors++;
            $display("[TB] FAIL %s: y=%h expected %h", name, y, exp);
        end
    endtask

    function automatic void addVec(input logic r, input count_t xv, input count_t e, input string n);
        vec_t v;
        v.rst  = r;
        v.x    = xv;
        v.exp  = e;
        v.name = n;
        vecs.push_back(v);
    endfunction

    initial begin
        count_t model;
        reset = 1'b1;
        x     = '0;

        // Reset held for three cycles.
        addVec(1'b1, 8'h00, 8'h00, "reset0");
        addVec(1'b1, 8'h00, 8'h00, "reset1");
        addVec(1'b1, 8'h00, 8'h00, "reset2");
        // Load 0x10, then decrement three times with x=0xFF.
        addVec(1'b0, 8'h10, 8'h10, "load10");
        addVec(1'b0, 8'hFF, 8'h0F, "dec1");
        addVec(1'b0, 8'hFF, 8'h0E, "dec2");
        addVec(1'b0, 8'hFF, 8'h0D, "dec3");
        // Move to 0xF0, overflow to 0x10, then hold with x=0.
        addVec(1'b0, 8'hE3, 8'hF0, "toF0");
        addVec(1'b0, 8'h20, 8'h10, "wrap20");
        addVec(1'b0, 8'h00, 8'h10, "hold1");
        addVec(1'b0, 8'h00, 8'h10, "hold2");
        addVec(1'b0, 8'h00, 8'h10, "hold3");
        addVec(1'b0, 8'h00, 8'h10, "hold4");
        addVec(1'b0, 8'h00, 8'h10, "hold5");
        // Reach 0x37, reset with nonzero x, then resume from zero.
        addVec(1'b0, 8'h27, 8'h37, "to37");
        addVec(1'b1, 8'h05, 8'h00, "rstMid");
        addVec(1'b0, 8'h05, 8'h05, "resume1");
        addVec(1'b0, 8'h05, 8'h0A, "resume2");
        addVec(1'b1, 8'hFF, 8'h00, "rstFF");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].x);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // Count by one through a full wrap after a fresh reset.
        applyStimulus(1'b1, 8'h00);
        checkOutput("sweepReset", 8'h00);
        for (int i = 1; i <= 256; i++) begin
            applyStimulus(1'b0, 8'h01);
            checkOutput($sformatf("sweep%0d", i), count_t'(i));
        end

        // Randomized run against a modulo model, with occasional resets.
        model = y;
        for (int i = 0; i < 1000; i++) begin
            logic   r;
            count_t xv;
            r  = ($urandom_range(0, 39) == 0);
            xv = count_t'($urandom);
            applyStimulus(r, xv);
            model = r ? 8'h00 : count_t'(model + xv);
            checkOutput($sformatf("rand%0d", i), model);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ctr_8

// File: doc/ctr_8.md
CTR_8 -- requirements
Module: ctr_8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width of x and y; the 8-bit instance uses the default.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port x, input, WIDTH, increment step added to the count each cycle.
REQ-005 SHALL have port y, output, WIDTH, current registered count.
REQ-006 SHALL use one clock, with reset synchronous and active-high; no asynchronous reset path.

Function
REQ-007 SHALL hold an internal WIDTH-bit count register that drives y directly, with no combinational path from x to y.
REQ-008 At each rising clk edge with reset=0, SHALL update count to (count + x) mod 2^WIDTH.
REQ-009 SHALL have 1-cycle latency: an x value sampled at edge N appears in y after edge N.
REQ-010 SHALL wrap silently on overflow, e.g. 8'hFF + 8'h01 -> 8'h00, with no saturation and no carry output.
REQ-011 SHALL hold y unchanged when x=0.
REQ-012 SHALL treat x as unsigned, so x=8'hFF acts as a modulo decrement by 1.
REQ-013 SHALL update on every clock edge; there is no enable or handshake.
REQ-014 SHALL give x no effect in any cycle where reset=1.

Reset
REQ-015 At a rising clk edge with reset=1, SHALL set count to 0, so y=8'h00 after that edge.
REQ-016 SHALL give reset priority over accumulation in every cycle, including mid-count and with x nonzero.
REQ-017 SHALL resume accumulation from 0 at the first edge after reset deasserts.
REQ-018 SHALL make y don't-care before the first reset edge; benches SHALL apply reset for at least 1 cycle.

Structure
REQ-019 SHALL define the default width constant (CTR_8_WIDTH = 8) in shared package ctr_8_pkg.
REQ-020 SHALL define a count typedef (logic [CTR_8_WIDTH-1:0]) in ctr_8_pkg.
REQ-021 SHALL place the modulo adder in one natural sub-module, ctr_8_add (inputs a, b; output sum, width WIDTH, carry discarded).
REQ-022 SHALL keep the register, reset logic and output assignment in ctr_8, in a single clocked process.

Verification
REQ-023 Reset for 3 cycles with x=0 -> y=0 after each reset edge.
REQ-024 Release reset, hold x=1 for 256 cycles -> y=1,2,...,255, then 0 after edge 256 (wrap).
REQ-025 From y=8'h10, apply x=8'hFF for 3 cycles -> y=8'h0F, 8'h0E, 8'h0D.
REQ-026 From y=8'hF0, apply x=8'h20 -> y=8'h10; then x=0 for 5 cycles -> y stays 8'h10.
REQ-027 At y=8'h37, assert reset for 1 cycle with x=8'h05 -> y=0; after deassert with x=5 -> y=5, 10.
REQ-028 Randomized x for 1000 cycles with occasional reset -> y matches a mod-256 reference model every cycle.
